mem_transfer_ctrl: RTL and testbench

//  Initiator side of the MemoryManager burst interface. Accepts one bulk request (read 16 B / write 1-16 B) from the CPU core.

---
 rtl/chip8_mem_pkg.sv | 17 +
 rtl/mem_transfer_ctrl.sv | 138 +++++++++++++
 tb/tb_mem_transfer_ctrl.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/chip8_mem_pkg.sv
// Shared types and constants for the CPU-side MemoryManager burst controller.
package chip8_mem_pkg;

  // Transfer sequencer states.
  typedef enum logic [2:0] {
    IDLE,
    READ,
    WRITE,
    SETTLE,
    DONE
  } xfer_state_t;

  localparam int         BURST_LEN   = 16;
  localparam logic [1:0] PHASE_READ  = 2'b00;
  localparam logic [1:0] PHASE_WRITE = 2'b01;

endpackage

// File: rtl/mem_transfer_ctrl.sv
// Initiator for MemoryManager bursts: one read (16 B) or write (1-16 B) per
// request, plus idle-time opcode fetch upkeep at pc.
module mem_transfer_ctrl #(
  parameter int ADDR_W    = 12,
  parameter int BURST_LEN = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_write,
  input  logic [ADDR_W-1:0]            req_addr,
  input  logic [$clog2(BURST_LEN)-1:0] req_count,
  input  logic [8*BURST_LEN-1:0]       req_data,
  output logic                         done,
  output logic [8*BURST_LEN-1:0]       rd_data,
  input  logic [ADDR_W-1:0]            pc,
  output logic                         opcode_valid,
  output logic [ADDR_W-1:0]            mem_address,
  output logic                         mem_write_enable,
  output logic [$clog2(BURST_LEN)-1:0] mem_write_count,
  output logic [8*BURST_LEN-1:0]       mem_write_buffer,
  output logic [$clog2(BURST_LEN)+1:0] mem_addr_counter,
  input  logic [8*BURST_LEN-1:0]       mem_read_buffer
);
  import chip8_mem_pkg::*;

  localparam int             IDX_W    = $clog2(BURST_LEN);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BURST_LEN - 1);

  xfer_state_t      state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic             tgl;
  logic             accept;
  logic [1:0]       seen, seen_cur;
  logic [ADDR_W-1:0] pc_q;

  assign accept   = req_valid && (state == IDLE);
  assign seen_cur = tgl ? 2'b10 : 2'b01;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state and memory-side strobes; counter is a pure function of state.
  always_comb begin
    state_nxt        = state;
    req_ready        = 1'b0;
    done             = 1'b0;
    mem_write_enable = 1'b0;
    mem_addr_counter = '0;
    case (state)
      IDLE: begin
        req_ready        = 1'b1;
        mem_addr_counter = {PHASE_READ, {(IDX_W-1){1'b0}}, tgl};
        if (req_valid) state_nxt = req_write ? WRITE : READ;
      end
      READ: begin
        mem_addr_counter = {PHASE_READ, idx};
        if (idx == IDX_LAST) state_nxt = SETTLE;
      end
      SETTLE: begin
        // Re-presents byte 0 so the last fetched byte is in read_buffer.
        state_nxt = DONE;
      end
      WRITE: begin
        mem_write_enable = 1'b1;
        mem_addr_counter = {PHASE_WRITE, idx};
        if (idx == mem_write_count) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Byte index advances while a burst stays in its data state, else restarts at 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      idx <= '0;
    else if ((state == READ || state == WRITE) && state_nxt == state)
      idx <= idx + 1'b1;
    else
      idx <= '0;
  end

  // Idle toggle drives the two-byte opcode fetch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)           tgl <= 1'b0;
    else if (state == IDLE) tgl <= ~tgl;
    else                    tgl <= 1'b0;
  end

  // Request latches hold until the next accept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_address      <= '0;
      mem_write_count  <= '0;
      mem_write_buffer <= '0;
    end else if (accept) begin
      mem_address      <= req_addr;
      mem_write_count  <= req_count;
      mem_write_buffer <= req_data;
    end
  end

  // Read result captured as SETTLE exits; writes never touch it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)             rd_data <= '0;
    else if (state == SETTLE) rd_data <= mem_read_buffer;
  end

  // Opcode coherence: both fetch halves must be presented under one stable pc.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q         <= '0;
      seen         <= '0;
      opcode_valid <= 1'b0;
    end else begin
      pc_q <= pc;
      if (state != IDLE || accept) begin
        seen         <= '0;
        opcode_valid <= 1'b0;
      end else if (pc != pc_q) begin
        seen         <= seen_cur;
        opcode_valid <= 1'b0;
      end else begin
        seen         <= seen | seen_cur;
        opcode_valid <= &(seen | seen_cur);
      end
    end
  end

endmodule

// File: tb/tb_mem_transfer_ctrl.sv
// Scoreboard bench for mem_transfer_ctrl with a behavioural MemoryManager.
module tb_mem_transfer_ctrl;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         req_write = 1'b0;
  logic [11:0]  req_addr = '0;
  logic [3:0]   req_count = '0;
  logic [127:0] req_data = '0;
  logic         done;
  logic [127:0] rd_data;
  logic [11:0]  pc = '0;
  logic         opcode_valid;
  logic [11:0]  mem_address;
  logic         mem_write_enable;
  logic [3:0]   mem_write_count;
  logic [127:0] mem_write_buffer;
  logic [5:0]   mem_addr_counter;
  logic [127:0] mem_read_buffer = '0;

  mem_transfer_ctrl #(.ADDR_W(12), .BURST_LEN(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_count(req_count), .req_data(req_data),
    .done(done), .rd_data(rd_data), .pc(pc), .opcode_valid(opcode_valid),
    .mem_address(mem_address), .mem_write_enable(mem_write_enable),
    .mem_write_count(mem_write_count), .mem_write_buffer(mem_write_buffer),
    .mem_addr_counter(mem_addr_counter), .mem_read_buffer(mem_read_buffer)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // MemoryManager model: 4 KiB byte array, registered read buffer and opcode.
  logic [7:0]  mem [4096];
  logic [15:0] opc = '0;
  logic        mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 8'(i);
      mem_init <= 1'b1;
    end else if (mem_write_enable) begin
      if (mem_addr_counter[3:0] <= mem_write_count)
        mem[12'(mem_address + 12'(mem_addr_counter[3:0]))] <=
          mem_write_buffer[8*mem_addr_counter[3:0] +: 8];
    end else if (mem_addr_counter[5:4] == 2'b00) begin
      mem_read_buffer[8*mem_addr_counter[3:0] +: 8] <=
        mem[12'(mem_address + 12'(mem_addr_counter[3:0]))];
      if (mem_addr_counter[3:0] == 4'd0) opc[15:8] <= mem[pc];
      if (mem_addr_counter[3:0] == 4'd1) opc[7:0]  <= mem[12'(pc + 12'd1)];
    end
  end

  // Reference model state.
  logic [7:0]   ref_mem [4096];
  logic [127:0] last_rd = '0;

  typedef struct {
    int unsigned  cyc;
    logic [127:0] rd;
    int           we;
    logic [11:0]  addr;
  } exp_t;
  exp_t sb_q[$];

  int checks = 0, errors = 0;
  int done_cnt = 0;
  int we_cnt = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] ref_read(input logic [11:0] a);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = ref_mem[(int'(a) + i) % 4096];
    return r;
  endfunction

  // Called at posedge+1. Returns one cycle after the accept edge.
  task automatic issue(input bit wr, input logic [11:0] a, input logic [3:0] cnt,
                       input logic [127:0] d, input bit hold, input bit immediate);
    exp_t e;
    int   w;
    bit   got;
    w = 0; got = 0;
    req_valid = 1'b1; req_write = wr; req_addr = a; req_count = cnt; req_data = d;
    while (!got && w < 50) begin
      @(negedge clk);
      if (req_ready) got = 1;
      else begin w++; @(posedge clk); #1; end
    end
    if (!got) begin
      chk("accept_timeout", 128'(0), 128'(1));
      req_valid = 1'b0;
      return;
    end
    if (immediate) chk("b2b_accept_wait", 128'(w), 128'(0));
    e.addr = a;
    if (wr) begin
      e.cyc = cyc + 32'(cnt) + 2;
      e.we  = int'(cnt) + 1;
      e.rd  = last_rd;
      for (int i = 0; i <= int'(cnt); i++) ref_mem[(int'(a) + i) % 4096] = d[8*i +: 8];
    end else begin
      e.cyc = cyc + 18;
      e.we  = 0;
      e.rd  = ref_read(a);
      last_rd = e.rd;
    end
    sb_q.push_back(e);
    @(posedge clk); #1;
    if (hold) begin
      req_addr = ~a; req_write = ~wr; req_data = ~d;
    end else begin
      req_valid = 1'b0;
    end
  endtask

  // Returns at posedge+1 of the cycle following the done pulse.
  task automatic wait_done(input bit hold);
    int start, n;
    start = done_cnt; n = 0;
    while (done_cnt == start && n < 60) begin
      if (hold) chk("busy_req_ready", 128'(req_ready), 128'(0));
      @(posedge clk); #1;
      n++;
    end
    if (done_cnt == start) chk("done_timeout", 128'(0), 128'(1));
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  logic [7:0] saved [10];

  initial begin
    for (int i = 0; i < 4096; i++) ref_mem[i] = 8'(i);
    fork
      // Monitor: per-cycle write-counter checks and done-pulse scoreboard pops.
      forever begin
        @(negedge clk);
        if (!reset_n) we_cnt = 0;
        else begin
          if (mem_write_enable) begin
            chk("we_counter", 128'(mem_addr_counter), 128'({2'b01, 4'(we_cnt)}));
            we_cnt++;
          end
          if (done) begin
            exp_t e;
            done_cnt++;
            if (sb_q.size() == 0) chk("unexpected_done", 128'(1), 128'(0));
            else begin
              e = sb_q.pop_front();
              chk("done_cycle", 128'(cyc), 128'(e.cyc));
              chk("rd_data", rd_data, e.rd);
              chk("we_cycles", 128'(we_cnt), 128'(e.we));
              chk("latched_addr", 128'(mem_address), 128'(e.addr));
            end
            we_cnt = 0;
          end
        end
      end
    join_none

    // Reset state.
    idle(3);
    chk("rst_ready", 128'(req_ready), 128'(1));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_we", 128'(mem_write_enable), 128'(0));
    chk("rst_counter", 128'(mem_addr_counter), 128'(0));
    chk("rst_opv", 128'(opcode_valid), 128'(0));
    chk("rst_rd_data", rd_data, 128'(0));
    chk("rst_addr", 128'({mem_address, mem_write_count}), 128'(0));
    chk("rst_wbuf", mem_write_buffer, 128'(0));
    @(posedge clk); #1 reset_n = 1'b1;
    idle(2);

    // Read 0x200 (preloaded 00..0F).
    issue(0, 12'h200, 4'd0, '0, 0, 0); wait_done(0);
    chk("read_200", rd_data, 128'h0F0E0D0C0B0A09080706050403020100);

    // Three-byte write, then read back.
    issue(1, 12'h300, 4'd2, 128'hCCBBAA, 0, 0); wait_done(0);
    issue(0, 12'h300, 4'd0, '0, 0, 0); wait_done(0);

    // Full 16-byte write across the top of memory.
    issue(1, 12'hFF8, 4'd15, {$urandom, $urandom, $urandom, $urandom}, 0, 0); wait_done(0);
    issue(0, 12'hFF8, 4'd0, '0, 0, 0); wait_done(0);
    issue(0, 12'h000, 4'd0, '0, 0, 0); wait_done(0);

    // Opcode tracking at pc=0x200 after planting 0x12,0x34.
    issue(1, 12'h200, 4'd1, 128'h3412, 0, 0); wait_done(0);
    idle(2);
    pc = 12'h200;
    idle(1);
    chk("opv_after_pc_change", 128'(opcode_valid), 128'(0));
    idle(1);
    chk("opv_earned", 128'(opcode_valid), 128'(1));
    chk("opcode", 128'(opc), 128'({ref_mem[12'h200], ref_mem[12'h201]}));
    pc = 12'h202;
    idle(1);
    chk("opv_drop", 128'(opcode_valid), 128'(0));
    idle(1);
    chk("opv_reearned", 128'(opcode_valid), 128'(1));
    chk("opcode2", 128'(opc), 128'({ref_mem[12'h202], ref_mem[12'h203]}));

    // req_valid held through a burst: one done only.
    issue(0, 12'h123, 4'd0, '0, 1, 0); wait_done(1);
    idle(2);

    // Back-to-back: next request in the cycle after done.
    issue(0, 12'h040, 4'd0, '0, 0, 0); wait_done(0);
    issue(1, 12'h045, 4'd4, {$urandom, $urandom, $urandom, $urandom}, 0, 1); wait_done(0);
    issue(0, 12'h040, 4'd0, '0, 0, 1); wait_done(0);

    // Reset during write index 5: bytes 0..4 land, no done.
    for (int i = 0; i < 10; i++) saved[i] = ref_mem[12'h500 + i];
    issue(1, 12'h500, 4'd9, {$urandom, $urandom, $urandom, $urandom}, 0, 0);
    idle(5);
    chk("abort_idx5", 128'(mem_addr_counter), 128'(6'h15));
    #1 reset_n = 1'b0;
    #1;
    chk("abort_we", 128'(mem_write_enable), 128'(0));
    chk("abort_ready", 128'(req_ready), 128'(1));
    chk("abort_done", 128'(done), 128'(0));
    chk("abort_counter", 128'(mem_addr_counter), 128'(0));
    sb_q.delete();
    last_rd = '0;
    for (int i = 5; i < 10; i++) ref_mem[12'h500 + i] = saved[i];
    idle(2);
    reset_n = 1'b1;
    idle(1);
    chk("abort_rd_data", rd_data, 128'(0));
    issue(0, 12'h500, 4'd0, '0, 0, 0); wait_done(0);

    // Randomized traffic against the reference memory.
    for (int n = 0; n < 40; n++) begin
      bit wr;
      wr = 1'($urandom);
      if ($urandom_range(0, 3) == 0) pc = 12'($urandom);
      issue(wr, 12'($urandom), 4'($urandom), {$urandom, $urandom, $urandom, $urandom}, 0, 0);
      wait_done(0);
      idle($urandom_range(0, 2));
    end

    idle(4);
    chk("sb_drained", 128'(sb_q.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
